// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg : shared FSM encoding and divisor constants for uart_tx_fifo
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int MIN_DIV     = 2;
   localparam int DEFAULT_DIV = 217;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo : synchronous byte FIFO, power-of-two depth, level/full/empty flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [7:0]               wr_data_i,
   input  logic                     pop_i,
   output logic [7:0]               rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push;
   logic             do_pop;

   // Flags come from the registered level only, so a pop never frees a slot early.
   assign full_o    = (level_q == LVL_W'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo : 8N1 UART transmitter fed by a byte FIFO, runtime baud divisor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DIV_W      = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   input  logic [DIV_W-1:0]              baud_div,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   tx_state_e        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_q, bit_d;
   logic             txd_q, txd_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_rd_data;
   logic [DIV_W-1:0] div_eff;
   logic             bit_end;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (wr_valid),
      .wr_data_i (wr_data),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   assign wr_ready = !fifo_full;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;
   assign txd      = txd_q;
   assign div_eff  = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
   assign bit_end  = (cnt_q == DIV_W'(1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      txd_d    = txd_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rd_data;
               div_d    = div_eff;
               cnt_d    = div_eff;
               txd_d    = 1'b0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               cnt_d   = div_q;
               bit_d   = 3'd0;
               txd_d   = shift_q[0];
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d = div_q;
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rd_data;
                  div_d    = div_eff;
                  cnt_d    = div_eff;
                  txd_d    = 1'b0;
                  state_d  = ST_START;
               end else begin
                  txd_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         default: begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= DIV_W'(MIN_DIV);
         div_q   <= DIV_W'(MIN_DIV);
         shift_q <= '0;
         bit_q   <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         txd_q   <= txd_d;
      end
   end

endmodule

`default_nettype wire
